// File: rtl/cpu_run_ctrl.sv
// CPU run controller: staged per-domain reset release, RUN cycle counting,
// stalled-PC halt detection and a watchdog timeout.
module cpu_run_ctrl #(
  parameter int NUM_DOMAINS = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int STAGGER     = 2,
  parameter int CNT_W       = 32,
  parameter int PC_W        = 32,
  parameter int STALL_LIMIT = 8,
  parameter int TIMEOUT     = 1000
) (
  input  logic                   clock_in,
  input  logic                   reset,
  input  logic                   soft_reset_req,
  input  logic [PC_W-1:0]        pc,
  input  logic                   pc_valid,
  output logic [NUM_DOMAINS-1:0] domain_rst_n,
  output logic                   running,
  output logic [CNT_W-1:0]       cycle_count,
  output logic                   halted,
  output logic                   timeout,
  output logic [PC_W-1:0]        halt_pc
);

  localparam int HOLD_W   = $clog2(HOLD_CYCLES + 1);
  localparam int LAST_REL = STAGGER * (NUM_DOMAINS - 1);
  localparam int REL_W    = $clog2(LAST_REL + 2);
  localparam int STALL_W  = $clog2(STALL_LIMIT + 1);

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RELEASE = 3'd1,
    ST_RUN     = 3'd2,
    ST_HALT    = 3'd3,
    ST_TMO     = 3'd4
  } state_t;

  state_t                 state_r;
  logic [HOLD_W-1:0]      hold_cnt_r;
  logic [REL_W-1:0]       rel_cnt_r;
  logic [STALL_W-1:0]     stall_cnt_r;
  logic [PC_W-1:0]        last_pc_r;
  logic                   last_valid_r;
  logic [NUM_DOMAINS-1:0] dom_rst_n_r;
  logic                   running_r;
  logic [CNT_W-1:0]       cycle_count_r;
  logic                   halted_r;
  logic                   timeout_r;
  logic [PC_W-1:0]        halt_pc_r;

  logic [NUM_DOMAINS-1:0] rel_hit_s;
  logic                   pc_match_s;
  logic                   stall_hit_s;
  logic                   tmo_hit_s;

  // Release-slot decode and halt/watchdog trigger conditions for this edge
  always_comb begin
    rel_hit_s = '0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      rel_hit_s[i] = (rel_cnt_r == REL_W'(STAGGER * i));
    end
    pc_match_s  = last_valid_r && (pc == last_pc_r);
    stall_hit_s = pc_valid && pc_match_s && (stall_cnt_r == STALL_W'(STALL_LIMIT - 1));
    tmo_hit_s   = (cycle_count_r == CNT_W'(TIMEOUT - 1));
  end

  // Controller FSM with registered outputs; soft restart behaves like reset
  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_HOLD;
      hold_cnt_r    <= '0;
      rel_cnt_r     <= '0;
      stall_cnt_r   <= '0;
      last_pc_r     <= '0;
      last_valid_r  <= 1'b0;
      dom_rst_n_r   <= '0;
      running_r     <= 1'b0;
      cycle_count_r <= '0;
      halted_r      <= 1'b0;
      timeout_r     <= 1'b0;
      halt_pc_r     <= '0;
    end else if (soft_reset_req) begin
      state_r       <= ST_HOLD;
      hold_cnt_r    <= '0;
      rel_cnt_r     <= '0;
      stall_cnt_r   <= '0;
      last_pc_r     <= '0;
      last_valid_r  <= 1'b0;
      dom_rst_n_r   <= '0;
      running_r     <= 1'b0;
      cycle_count_r <= '0;
      halted_r      <= 1'b0;
      timeout_r     <= 1'b0;
      halt_pc_r     <= '0;
    end else begin
      case (state_r)
        ST_HOLD: begin
          if (hold_cnt_r == HOLD_W'(HOLD_CYCLES - 1)) begin
            state_r    <= ST_RELEASE;
            hold_cnt_r <= '0;
            rel_cnt_r  <= '0;
          end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
          end
        end
        ST_RELEASE: begin
          dom_rst_n_r <= dom_rst_n_r | rel_hit_s;
          rel_cnt_r   <= rel_cnt_r + REL_W'(1);
          // The last domain's release edge hands over so the next edge is RUN edge 1
          if (rel_cnt_r == REL_W'(LAST_REL)) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_RELEASE;
          end
        end
        ST_RUN: begin
          cycle_count_r <= cycle_count_r + CNT_W'(1);
          if (pc_valid) begin
            if (pc_match_s) begin
              stall_cnt_r <= stall_cnt_r + STALL_W'(1);
            end else begin
              last_pc_r    <= pc;
              stall_cnt_r  <= STALL_W'(1);
              last_valid_r <= 1'b1;
            end
          end
          // Halt outranks the watchdog when both land on the same edge
          if (stall_hit_s) begin
            state_r   <= ST_HALT;
            halted_r  <= 1'b1;
            halt_pc_r <= pc;
            running_r <= 1'b0;
          end else if (tmo_hit_s) begin
            state_r   <= ST_TMO;
            timeout_r <= 1'b1;
            running_r <= 1'b0;
          end else begin
            running_r <= 1'b1;
          end
        end
        ST_HALT: state_r <= ST_HALT;
        ST_TMO:  state_r <= ST_TMO;
        default: state_r <= ST_HOLD;
      endcase
    end
  end

  assign domain_rst_n = dom_rst_n_r;
  assign running      = running_r;
  assign cycle_count  = cycle_count_r;
  assign halted       = halted_r;
  assign timeout      = timeout_r;
  assign halt_pc      = halt_pc_r;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: two instances (watchdog 20 and 8) share
// stimulus; per-edge expected snapshots are queued at drive time and compared.
module tb_cpu_run_ctrl;

  localparam int ND   = 2;
  localparam int HOLD = 4;
  localparam int STG  = 2;
  localparam int SL   = 8;
  localparam int TO_A = 20;
  localparam int TO_B = 8;
  localparam int RUN_E = HOLD + STG * (ND - 1) + 2;

  typedef struct packed {
    int          e;
    int          runs;
    int          stall;
    logic        lv;
    logic [31:0] last;
    logic        hlt;
    logic        tmo;
    logic [31:0] hpc;
  } mdl_t;

  typedef struct packed {
    logic [ND-1:0] dom;
    logic          run;
    logic [31:0]   cnt;
    logic          hlt;
    logic          tmo;
    logic [31:0]   hpc;
  } snap_t;

  logic        clk;
  logic        rst_n;
  logic        soft_reset_req;
  logic [31:0] pc;
  logic        pc_valid;

  logic [ND-1:0] dom_a, dom_b;
  logic          run_a, run_b, hlt_a, hlt_b, tmo_a, tmo_b;
  logic [31:0]   cnt_a, cnt_b, hpc_a, hpc_b;

  int    n_total;
  int    n_bad;
  mdl_t  ma, mb;
  snap_t qa[$];
  snap_t qb[$];

  cpu_run_ctrl #(.NUM_DOMAINS(ND), .HOLD_CYCLES(HOLD), .STAGGER(STG), .CNT_W(32),
                 .PC_W(32), .STALL_LIMIT(SL), .TIMEOUT(TO_A)) dut_a (
    .clock_in(clk), .reset(rst_n), .soft_reset_req(soft_reset_req), .pc(pc),
    .pc_valid(pc_valid), .domain_rst_n(dom_a), .running(run_a), .cycle_count(cnt_a),
    .halted(hlt_a), .timeout(tmo_a), .halt_pc(hpc_a));

  cpu_run_ctrl #(.NUM_DOMAINS(ND), .HOLD_CYCLES(HOLD), .STAGGER(STG), .CNT_W(32),
                 .PC_W(32), .STALL_LIMIT(SL), .TIMEOUT(TO_B)) dut_b (
    .clock_in(clk), .reset(rst_n), .soft_reset_req(soft_reset_req), .pc(pc),
    .pc_valid(pc_valid), .domain_rst_n(dom_b), .running(run_b), .cycle_count(cnt_b),
    .halted(hlt_b), .timeout(tmo_b), .halt_pc(hpc_b));

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Edge-count view of the controller: releases and RUN entry follow from e
  function automatic mdl_t step(input mdl_t m, input logic [31:0] p, input logic v,
                                input logic s, input int to);
    mdl_t r;
    r = m;
    if (s) begin
      r = '0;
      return r;
    end
    if (r.hlt || r.tmo) return r;
    r.e++;
    if (r.e >= RUN_E) begin
      r.runs++;
      if (v) begin
        if (r.lv && p == r.last) r.stall++;
        else begin
          r.last  = p;
          r.stall = 1;
          r.lv    = 1'b1;
        end
        if (r.stall == SL) begin
          r.hlt = 1'b1;
          r.hpc = p;
        end
      end
      if (!r.hlt && r.runs == to) r.tmo = 1'b1;
    end
    return r;
  endfunction

  function automatic snap_t expect_of(input mdl_t m);
    snap_t x;
    x = '0;
    for (int i = 0; i < ND; i++) x.dom[i] = (m.e >= HOLD + 1 + STG * i);
    x.run = (m.e >= RUN_E) && !m.hlt && !m.tmo;
    x.cnt = 32'(m.runs);
    x.hlt = m.hlt;
    x.tmo = m.tmo;
    x.hpc = m.hpc;
    return x;
  endfunction

  task automatic compare_all();
    snap_t ea, eb;
    ea = qa.pop_front();
    eb = qb.pop_front();
    check_val("a_dom", 64'(dom_a), 64'(ea.dom));
    check_val("a_running", 64'(run_a), 64'(ea.run));
    check_val("a_count", 64'(cnt_a), 64'(ea.cnt));
    check_val("a_halted", 64'(hlt_a), 64'(ea.hlt));
    check_val("a_timeout", 64'(tmo_a), 64'(ea.tmo));
    check_val("a_halt_pc", 64'(hpc_a), 64'(ea.hpc));
    check_val("b_dom", 64'(dom_b), 64'(eb.dom));
    check_val("b_running", 64'(run_b), 64'(eb.run));
    check_val("b_count", 64'(cnt_b), 64'(eb.cnt));
    check_val("b_halted", 64'(hlt_b), 64'(eb.hlt));
    check_val("b_timeout", 64'(tmo_b), 64'(eb.tmo));
    check_val("b_halt_pc", 64'(hpc_b), 64'(eb.hpc));
  endtask

  task automatic tick(input logic [31:0] p, input logic v, input logic s);
    pc             = p;
    pc_valid       = v;
    soft_reset_req = s;
    ma = step(ma, p, v, s, TO_A);
    mb = step(mb, p, v, s, TO_B);
    qa.push_back(expect_of(ma));
    qb.push_back(expect_of(mb));
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic bring_up();
    repeat (7) tick(32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    soft_reset_req = 1'b0;
    pc       = 32'h0;
    pc_valid = 1'b0;
    ma = '0;
    mb = '0;
    #1;
    qa.push_back(expect_of(ma));
    qb.push_back(expect_of(mb));
    compare_all();
    #19 rst_n = 1'b1;

    // Bring-up timing with explicit edge checkpoints
    repeat (4) tick(32'h0, 1'b0, 1'b0);
    check_val("e4_dom", 64'(dom_a), 64'h0);
    tick(32'h0, 1'b0, 1'b0);
    check_val("e5_dom", 64'(dom_a), 64'h1);
    repeat (2) tick(32'h0, 1'b0, 1'b0);
    check_val("e7_dom", 64'(dom_a), 64'h3);
    check_val("e7_running", 64'(run_a), 64'h0);

    // Halt on a held PC after three distinct samples
    tick(32'h10, 1'b1, 1'b0);
    check_val("e8_running", 64'(run_a), 64'h1);
    check_val("e8_count", 64'(cnt_a), 64'h1);
    tick(32'h14, 1'b1, 1'b0);
    tick(32'h18, 1'b1, 1'b0);
    repeat (8) tick(32'h1C, 1'b1, 1'b0);
    check_val("s2_halted", 64'(hlt_a), 64'h1);
    check_val("s2_halt_pc", 64'(hpc_a), 64'h1C);
    check_val("s2_count", 64'(cnt_a), 64'd11);
    repeat (3) tick(32'h20, 1'b1, 1'b0);
    check_val("s2_frozen", 64'(cnt_a), 64'd11);

    // Soft restart after halt, then again mid-release
    tick(32'h0, 1'b0, 1'b1);
    check_val("srst_halted", 64'(hlt_a), 64'h0);
    check_val("srst_count", 64'(cnt_a), 64'h0);
    repeat (5) tick(32'h0, 1'b0, 1'b0);
    check_val("rel_dom", 64'(dom_a), 64'h1);
    tick(32'h0, 1'b0, 1'b1);
    check_val("rel_srst_dom", 64'(dom_a), 64'h0);
    bring_up();

    // Gap of invalid samples inside the stall run delays halt
    tick(32'h10, 1'b1, 1'b0);
    tick(32'h14, 1'b1, 1'b0);
    tick(32'h18, 1'b1, 1'b0);
    repeat (4) tick(32'h1C, 1'b1, 1'b0);
    repeat (3) tick(32'h55, 1'b0, 1'b0);
    repeat (3) tick(32'h1C, 1'b1, 1'b0);
    check_val("s3_not_yet", 64'(hlt_a), 64'h0);
    tick(32'h1C, 1'b1, 1'b0);
    check_val("s3_halted", 64'(hlt_a), 64'h1);
    check_val("s3_count", 64'(cnt_a), 64'd14);

    // Watchdog with a moving PC
    tick(32'h0, 1'b0, 1'b1);
    bring_up();
    for (int i = 0; i < 19; i++) tick(32'h100 + 32'(4 * i), 1'b1, 1'b0);
    check_val("s4_pre_tmo", 64'(tmo_a), 64'h0);
    tick(32'h200, 1'b1, 1'b0);
    check_val("s4_timeout", 64'(tmo_a), 64'h1);
    check_val("s4_count", 64'(cnt_a), 64'd20);
    check_val("s4_halted", 64'(hlt_a), 64'h0);
    check_val("s4_dom", 64'(dom_a), 64'h3);
    repeat (2) tick(32'h204, 1'b1, 1'b0);

    // Halt and watchdog on the same edge
    tick(32'h0, 1'b0, 1'b1);
    bring_up();
    repeat (8) tick(32'h40, 1'b1, 1'b0);
    check_val("s5_halted", 64'(hlt_b), 64'h1);
    check_val("s5_timeout", 64'(tmo_b), 64'h0);
    check_val("s5_count", 64'(cnt_b), 64'd8);

    // Held restart, then async reset mid-RUN
    repeat (3) tick(32'h0, 1'b0, 1'b1);
    bring_up();
    repeat (3) tick(32'h60, 1'b1, 1'b0);
    #10 rst_n = 1'b0;
    #1;
    ma = '0;
    mb = '0;
    qa.push_back(expect_of(ma));
    qb.push_back(expect_of(mb));
    compare_all();
    check_val("arst_running", 64'(run_a), 64'h0);
    check_val("arst_dom", 64'(dom_a), 64'h0);
    #10 rst_n = 1'b1;
    bring_up();
    repeat (2) tick(32'h70, 1'b1, 1'b0);
    check_val("post_arst_count", 64'(cnt_a), 64'd2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
